// File: rtl/bsg_fifo_rolly_pkg.sv
// Shared widths and count payload for the multi-commit rollback FIFO.
package bsg_fifo_rolly_pkg;

  localparam int unsigned cnt_max_width = 32;

  function automatic int unsigned ptr_width(input int unsigned els);
    return $clog2(2 * els);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

  typedef struct packed {
    logic [cnt_max_width-1:0] free;
    logic [cnt_max_width-1:0] unread;
    logic [cnt_max_width-1:0] uncommitted;
  } rolly_cnt_s;

endpackage

// File: rtl/bsg_rolly_ptr.sv
// Modulo-2*els_p pointer register with load or add, plus its storage address.
module bsg_rolly_ptr
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int unsigned els_p       = 4,
  parameter int unsigned add_width_p = 1,
  localparam int unsigned ptr_w_lp   = ptr_width(els_p),
  localparam int unsigned addr_w_lp  = $clog2(els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   load_v_i,
  input  logic [ptr_w_lp-1:0]    load_val_i,
  input  logic [add_width_p-1:0] add_i,
  output logic [ptr_w_lp-1:0]    ptr_o,
  output logic [addr_w_lp-1:0]   addr_o,
  output logic [ptr_w_lp-1:0]    ptr_next_c
);

  localparam int unsigned sum_w_lp = ptr_w_lp + 1;
  localparam int unsigned span_lp  = 2 * els_p;

  logic [ptr_w_lp-1:0] ptr_r;
  logic [sum_w_lp-1:0] sum_c;

  assign sum_c = sum_w_lp'(ptr_r) + sum_w_lp'(add_i);

  // Add amount never exceeds els_p, so one conditional subtraction wraps.
  always_comb begin
    ptr_next_c = ptr_w_lp'(sum_c);
    if (load_v_i) begin
      ptr_next_c = load_val_i;
    end else if (sum_c >= sum_w_lp'(span_lp)) begin
      ptr_next_c = ptr_w_lp'(sum_c - sum_w_lp'(span_lp));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_r <= '0;
    else            ptr_r <= ptr_next_c;
  end

  assign ptr_o  = ptr_r;
  assign addr_o = (ptr_r >= ptr_w_lp'(els_p)) ? addr_w_lp'(ptr_r - ptr_w_lp'(els_p))
                                              : addr_w_lp'(ptr_r);

endmodule

// File: rtl/bsg_fifo_1r1w_rolly_mc.sv
// Rollback FIFO: speculative reads, bulk commit, roll and clear, occupancy counts.
// Define BSG_FIFO_ROLLY_MC_CHECK_EN to add err_o and suppress illegal operations.
module bsg_fifo_1r1w_rolly_mc
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int unsigned width_p            = 8,
  parameter int unsigned els_p              = 4,
  parameter int unsigned max_commit_p       = 1,
  parameter int unsigned ready_then_valid_p = 0,
  localparam int unsigned ptr_w_lp    = ptr_width(els_p),
  localparam int unsigned cnt_w_lp    = cnt_width(els_p),
  localparam int unsigned commit_w_lp = $clog2(max_commit_p + 1),
  localparam int unsigned addr_w_lp   = $clog2(els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
`ifdef BSG_FIFO_ROLLY_MC_CHECK_EN
  output logic                   err_o,
`endif
  input  logic                   clr_v_i,
  input  logic                   roll_v_i,
  input  logic [commit_w_lp-1:0] commit_cnt_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [width_p-1:0]     data_o,
  output logic                   v_o,
  input  logic                   yumi_i,
  output logic [cnt_w_lp-1:0]    free_cnt_o,
  output logic [cnt_w_lp-1:0]    unread_cnt_o,
  output logic [cnt_w_lp-1:0]    uncommitted_cnt_o
);

  localparam int unsigned sum_w_lp = ptr_w_lp + 1;
  localparam int unsigned span_lp  = 2 * els_p;

  function automatic logic [ptr_w_lp-1:0] ptr_dist(input logic [ptr_w_lp-1:0] a,
                                                   input logic [ptr_w_lp-1:0] b);
    logic [sum_w_lp-1:0] d;
    if (a >= b) d = sum_w_lp'(a) - sum_w_lp'(b);
    else        d = sum_w_lp'(a) + sum_w_lp'(span_lp) - sum_w_lp'(b);
    return ptr_w_lp'(d);
  endfunction

  logic [ptr_w_lp-1:0]    wptr, rptr, cptr;
  logic [ptr_w_lp-1:0]    cptr_next_c, rptr_next_c, wptr_next_unused;
  logic [addr_w_lp-1:0]   waddr, raddr, cptr_addr_unused;
  logic [ptr_w_lp-1:0]    dist_wc_c, dist_wr_c, dist_rc_c;
  logic                   full_c, empty_c, enq_raw_c;
  logic                   enq_eff_c, yumi_eff_c;
  logic [commit_w_lp-1:0] commit_eff_c;
  rolly_cnt_s             cnt_c;
  logic [width_p-1:0]     mem_r [els_p];

  assign dist_wc_c = ptr_dist(wptr, cptr);
  assign dist_wr_c = ptr_dist(wptr, rptr);
  assign dist_rc_c = ptr_dist(rptr, cptr);

  // Free space is bounded by the commit pointer, not the read pointer.
  assign full_c  = (dist_wc_c == ptr_w_lp'(els_p));
  assign empty_c = (rptr == wptr);

  assign ready_o   = ~clr_v_i & ~full_c;
  assign v_o       = ~roll_v_i & ~empty_c;
  assign enq_raw_c = v_i & ((ready_then_valid_p != 0) | ready_o);

`ifdef BSG_FIFO_ROLLY_MC_CHECK_EN
  logic err_r, yumi_err_c, commit_err_c, enq_err_c;

  assign yumi_err_c   = yumi_i & ~v_o;
  assign yumi_eff_c   = yumi_i & v_o;
  assign commit_err_c = sum_w_lp'(commit_cnt_i) > (sum_w_lp'(dist_rc_c) + sum_w_lp'(yumi_eff_c));
  assign commit_eff_c = commit_err_c ? '0 : commit_cnt_i;
  assign enq_err_c    = enq_raw_c & full_c;
  assign enq_eff_c    = enq_raw_c & ~full_c;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_r <= 1'b0;
    else            err_r <= err_r | yumi_err_c | commit_err_c | enq_err_c;
  end

  assign err_o = err_r;
`else
  assign yumi_eff_c   = yumi_i;
  assign commit_eff_c = commit_cnt_i;
  assign enq_eff_c    = enq_raw_c;
`endif

  bsg_rolly_ptr #(.els_p(els_p), .add_width_p(commit_w_lp)) u_cptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_v_i   (1'b0),
    .load_val_i ('0),
    .add_i      (commit_eff_c),
    .ptr_o      (cptr),
    .addr_o     (cptr_addr_unused),
    .ptr_next_c (cptr_next_c)
  );

  // Roll rewinds to the post-commit position of this cycle.
  bsg_rolly_ptr #(.els_p(els_p), .add_width_p(1)) u_rptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_v_i   (roll_v_i),
    .load_val_i (cptr_next_c),
    .add_i      (yumi_eff_c),
    .ptr_o      (rptr),
    .addr_o     (raddr),
    .ptr_next_c (rptr_next_c)
  );

  // Clear drops unread entries by pulling the write pointer back to the next read position.
  bsg_rolly_ptr #(.els_p(els_p), .add_width_p(1)) u_wptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_v_i   (clr_v_i),
    .load_val_i (rptr_next_c),
    .add_i      (enq_eff_c),
    .ptr_o      (wptr),
    .addr_o     (waddr),
    .ptr_next_c (wptr_next_unused)
  );

  always_ff @(posedge clk_i) begin
    if (enq_eff_c) mem_r[waddr] <= data_i;
  end

  assign data_o = mem_r[raddr];

  always_comb begin
    cnt_c             = '0;
    cnt_c.free        = cnt_max_width'(ptr_w_lp'(els_p) - dist_wc_c);
    cnt_c.unread      = cnt_max_width'(dist_wr_c);
    cnt_c.uncommitted = cnt_max_width'(dist_rc_c);
  end

  assign free_cnt_o        = cnt_w_lp'(cnt_c.free);
  assign unread_cnt_o      = cnt_w_lp'(cnt_c.unread);
  assign uncommitted_cnt_o = cnt_w_lp'(cnt_c.uncommitted);

endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_mc.sv
// Directed bench for the rollback FIFO: scoreboard of enqueued data, pointer model for counts.
module tb_bsg_fifo_1r1w_rolly_mc;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       clr_v_i, roll_v_i, v_i, yumi_i;
  logic [1:0] commit_cnt_i;
  logic [7:0] data_i, data_o;
  logic       ready_o, v_o;
  logic [2:0] free_cnt_o, unread_cnt_o, uncommitted_cnt_o;
`ifdef BSG_FIFO_ROLLY_MC_CHECK_EN
  logic       err_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  int w = 0, r = 0, c = 0;
  logic [7:0] hist[$];

  always #5 clk_i = ~clk_i;

  bsg_fifo_1r1w_rolly_mc #(
    .width_p(8), .els_p(4), .max_commit_p(2), .ready_then_valid_p(0)
  ) dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
`ifdef BSG_FIFO_ROLLY_MC_CHECK_EN
    .err_o             (err_o),
`endif
    .clr_v_i           (clr_v_i),
    .roll_v_i          (roll_v_i),
    .commit_cnt_i      (commit_cnt_i),
    .data_i            (data_i),
    .v_i               (v_i),
    .ready_o           (ready_o),
    .data_o            (data_o),
    .v_o               (v_o),
    .yumi_i            (yumi_i),
    .free_cnt_o        (free_cnt_o),
    .unread_cnt_o      (unread_cnt_o),
    .uncommitted_cnt_o (uncommitted_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    v_i = 1'b0; data_i = 8'h00; yumi_i = 1'b0;
    commit_cnt_i = 2'd0; roll_v_i = 1'b0; clr_v_i = 1'b0;
  endtask

  // One clock: drive, check outputs against the model, update the model, advance.
  task automatic cycle(input logic v, input logic [7:0] d, input logic y,
                       input int cm, input logic rl, input logic cl);
    logic exp_rdy, exp_v, enq;
    int   rn;
    v_i = v; data_i = d; yumi_i = y; commit_cnt_i = 2'(cm); roll_v_i = rl; clr_v_i = cl;
    #1;
    exp_rdy = !cl && ((w - c) != 4);
    exp_v   = !rl && ((w - r) != 0);
    chk("ready_o", 32'(ready_o), 32'(exp_rdy));
    chk("v_o", 32'(v_o), 32'(exp_v));
    if (exp_v) chk("data_o", 32'(data_o), 32'(hist[r]));
    chk("free_cnt", 32'(free_cnt_o), 32'(4 - (w - c)));
    chk("unread_cnt", 32'(unread_cnt_o), 32'(w - r));
    chk("uncommitted_cnt", 32'(uncommitted_cnt_o), 32'(r - c));
`ifdef BSG_FIFO_ROLLY_MC_CHECK_EN
    chk("err_quiet", 32'(err_o), 32'd0);
`endif
    enq = v && exp_rdy;
    if (enq) hist.push_back(d);
    rn = rl ? (c + cm) : (r + int'(y));
    c  = c + cm;
    r  = rn;
    w  = cl ? rn : (w + int'(enq));
    while (hist.size() > w) void'(hist.pop_back());
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  initial begin
    int un, cm;
    logic y;
    idle_inputs();
    reset_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_free", 32'(free_cnt_o), 32'd4);
    chk("rst_unread", 32'(unread_cnt_o), 32'd0);
    chk("rst_uncommitted", 32'(uncommitted_cnt_o), 32'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Fill to full.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA1 + i), 1'b0, 0, 1'b0, 1'b0);
    chk("fill_ready", 32'(ready_o), 32'd0);
    chk("fill_v", 32'(v_o), 32'd1);
    chk("fill_data", 32'(data_o), 32'h0000_00A1);
    chk("fill_free", 32'(free_cnt_o), 32'd0);

    // Read everything without committing: still full via cptr.
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    chk("read_all_v", 32'(v_o), 32'd0);
    chk("read_all_ready", 32'(ready_o), 32'd0);
    chk("read_all_uncom", 32'(uncommitted_cnt_o), 32'd4);
    cycle(1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0);
    chk("commit2_ready", 32'(ready_o), 32'd1);
    chk("commit2_free", 32'(free_cnt_o), 32'd2);
    cycle(1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0);

    // Roll with a partial commit.
    cycle(1'b1, 8'hB1, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'hB2, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    chk("pre_roll_uncom", 32'(uncommitted_cnt_o), 32'd2);
    cycle(1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b0);
    chk("roll_data", 32'(data_o), 32'h0000_00B2);
    chk("roll_uncom", 32'(uncommitted_cnt_o), 32'd0);
    chk("roll_unread", 32'(unread_cnt_o), 32'd1);

    // Clear with a same-cycle read and a blocked enqueue.
    cycle(1'b1, 8'hC1, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 0, 1'b0, 1'b1);
    chk("clr_unread", 32'(unread_cnt_o), 32'd0);
    chk("clr_v", 32'(v_o), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0);
    cycle(1'b1, 8'hD1, 1'b0, 0, 1'b0, 1'b0);
    chk("post_clr_data", 32'(data_o), 32'h0000_00D1);

    // Mixed enqueue/read/commit traffic across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      un = w - r;
      y  = (un > 0) && (i % 3 != 2);
      cm = (r - c) + int'(y);
      if (cm > 2) cm = 2;
      cycle(i % 5 != 4, 8'(8'h40 + i), y, cm, 1'b0, 1'b0);
      chk("wrap_bound", 32'(free_cnt_o <= 3'd4 && unread_cnt_o <= 3'd4), 32'd1);
    end

`ifdef BSG_FIFO_ROLLY_MC_CHECK_EN
    // Over-commit is flagged, suppressed, and sticky until reset.
    while (r - c > 0) cycle(1'b0, 8'h00, 1'b0, (r - c > 2) ? 2 : (r - c), 1'b0, 1'b0);
    if (w == r) cycle(1'b1, 8'h77, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    chk("err_setup_uncom", 32'(uncommitted_cnt_o), 32'd1);
    commit_cnt_i = 2'd2;
    @(posedge clk_i);
    #1;
    idle_inputs();
    chk("err_set", 32'(err_o), 32'd1);
    chk("err_cptr_held", 32'(uncommitted_cnt_o), 32'd1);
    @(posedge clk_i);
    #1;
    chk("err_sticky", 32'(err_o), 32'd1);
    reset_n_i = 1'b0;
    #1;
    chk("err_reset", 32'(err_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
